// File: rtl/scam_rr_channel_arbiter_pkg.sv
// rtl/scam_rr_channel_arbiter_pkg.sv - shared types for the round-robin channel arbiter
package scam_arb_types;

  typedef enum logic [1:0] {ARB, TAKE, SEND} arb_state_t;

  localparam int CNT_W = 8;

endpackage

// File: rtl/scam_rr_channel_arbiter_pick.sv
// rtl/scam_rr_channel_arbiter_pick.sv - combinational round-robin picker, search starts at ptr
module scam_rr_pick #(
  parameter int NUM_REQ = 4,
  localparam int IDX_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               found,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IDX_W-1:0]   idx
);

  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;

  // Rotate so that bit 0 of rot is requester ptr; the lowest set bit wins.
  assign dbl = {req, req};
  assign rot = NUM_REQ'(dbl >> ptr);

  always_comb begin
    int off;
    int cand;
    found  = 1'b0;
    onehot = '0;
    idx    = '0;
    off    = 0;
    cand   = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        off   = k;
      end
    end
    cand = int'(ptr) + off;
    if (cand >= NUM_REQ) cand = cand - NUM_REQ;
    idx = IDX_W'(cand);
    if (found) onehot = NUM_REQ'(1) << idx;
  end

endmodule

// File: rtl/scam_rr_channel_arbiter.sv
// rtl/scam_rr_channel_arbiter.sv - shares one blocking channel among NUM_REQ producers, one word per grant
module scam_rr_channel_arbiter
  import scam_arb_types::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  localparam int IDX_W  = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ*DATA_W-1:0] req_in,
  input  logic [NUM_REQ-1:0]        req_in_sync,
  output logic [NUM_REQ-1:0]        req_in_notify,
  output logic [DATA_W-1:0]         b_out,
  input  logic                      b_out_sync,
  output logic                      b_out_notify,
  output logic [IDX_W+CNT_W-1:0]    m_out,
  output logic                      m_out_notify
);

  arb_state_t state, state_nxt;

  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   grant;
  logic [DATA_W-1:0]  buf_q;
  logic [CNT_W-1:0]   xfer_cnt;
  logic [CNT_W-1:0]   cnt_inc;
  logic               pick_found;
  logic [NUM_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0]   pick_idx;
  logic               take_fire;
  logic               send_fire;

  scam_rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_pick (
    .req    (req_in_sync),
    .ptr    (rr_ptr),
    .found  (pick_found),
    .onehot (pick_onehot),
    .idx    (pick_idx)
  );

  assign take_fire = (state == TAKE) && req_in_sync[grant];
  assign send_fire = (state == SEND) && b_out_sync;
  assign cnt_inc   = xfer_cnt + CNT_W'(1);
  assign b_out     = buf_q;

  always_comb begin
    state_nxt = state;
    case (state)
      ARB:     if (pick_found) state_nxt = TAKE;
      TAKE:    if (take_fire)  state_nxt = SEND;
      SEND:    if (send_fire)  state_nxt = ARB;
      default: state_nxt = ARB;
    endcase
  end

  // Non-granted sync bits are only looked at in ARB, so the decision stays frozen until then.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= ARB;
      rr_ptr        <= '0;
      grant         <= '0;
      buf_q         <= '0;
      xfer_cnt      <= '0;
      req_in_notify <= '0;
      b_out_notify  <= 1'b0;
      m_out         <= '0;
      m_out_notify  <= 1'b0;
    end else begin
      state        <= state_nxt;
      m_out_notify <= 1'b0;
      case (state)
        ARB: begin
          if (pick_found) begin
            grant         <= pick_idx;
            req_in_notify <= pick_onehot;
          end
        end
        TAKE: begin
          if (take_fire) begin
            buf_q         <= req_in[grant*DATA_W +: DATA_W];
            req_in_notify <= '0;
            b_out_notify  <= 1'b1;
          end
        end
        SEND: begin
          if (send_fire) begin
            b_out_notify <= 1'b0;
            rr_ptr       <= (grant == IDX_W'(NUM_REQ - 1)) ? '0 : grant + IDX_W'(1);
            xfer_cnt     <= cnt_inc;
            m_out        <= {grant, cnt_inc};
            m_out_notify <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_scam_rr_channel_arbiter.sv
// tb/tb_scam_rr_channel_arbiter.sv - self-checking bench with a transaction-level reference model
module tb_scam_rr_channel_arbiter;

  localparam int N = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N*W-1:0] req_in = '0;
  logic [N-1:0]   req_in_sync = '0;
  logic [N-1:0]   req_in_notify;
  logic [W-1:0]   b_out;
  logic           b_out_sync = 1'b0;
  logic           b_out_notify;
  logic [9:0]     m_out;
  logic           m_out_notify;

  scam_rr_channel_arbiter #(.NUM_REQ(N), .DATA_W(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_in        (req_in),
    .req_in_sync   (req_in_sync),
    .req_in_notify (req_in_notify),
    .b_out         (b_out),
    .b_out_sync    (b_out_sync),
    .b_out_notify  (b_out_notify),
    .m_out         (m_out),
    .m_out_notify  (m_out_notify)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: which requester holds the grant (-1 = none), whether a word is on offer downstream.
  int          m_grant = -1;
  bit          m_offer = 0;
  int          m_ptr = 0;
  int          m_cnt = 0;
  logic [31:0] m_word = '0;
  logic [9:0]  m_mout = '0;
  bit          m_strobe = 0;
  logic [N-1:0] hs = '0;

  int fill_mode = 0;
  int bready_pct = 100;
  int seq [N];
  logic [9:0]  obs_m[$];
  logic [31:0] obs_b[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_grant = -1; m_offer = 0; m_ptr = 0; m_cnt = 0;
    m_word = '0; m_mout = '0; m_strobe = 0;
  endtask

  // Advance the model by one clock edge using the inputs presented before that edge.
  task automatic model_edge();
    bit done;
    int j;
    hs = '0;
    m_strobe = 0;
    if (!rst) begin
      model_reset();
      return;
    end
    if (m_offer) begin
      if (b_out_sync) begin
        m_offer = 0;
        m_ptr = (m_grant + 1) % N;
        m_cnt = (m_cnt + 1) % 256;
        m_mout = {m_grant[1:0], m_cnt[7:0]};
        m_strobe = 1;
        m_grant = -1;
      end
    end else if (m_grant >= 0) begin
      if (req_in_sync[m_grant]) begin
        m_word = req_in[m_grant*W +: W];
        m_offer = 1;
        hs[m_grant] = 1'b1;
      end
    end else begin
      done = 0;
      for (int k = 0; k < N; k++) begin
        j = (m_ptr + k) % N;
        if (!done && req_in_sync[j]) begin
          m_grant = j;
          done = 1;
        end
      end
    end
  endtask

  task automatic check_outputs();
    logic [N-1:0] exp_n;
    exp_n = '0;
    if (m_grant >= 0 && !m_offer) exp_n[m_grant] = 1'b1;
    chk("req_in_notify", 64'(req_in_notify), 64'(exp_n));
    chk("b_out_notify", 64'(b_out_notify), 64'(m_offer));
    chk("b_out", 64'(b_out), 64'(m_word));
    chk("m_out_notify", 64'(m_out_notify), 64'(m_strobe));
    chk("m_out", 64'(m_out), 64'(m_mout));
    if (m_out_notify) begin
      obs_m.push_back(m_out);
      obs_b.push_back(b_out);
    end
  endtask

  task automatic drive_next();
    for (int i = 0; i < N; i++) begin
      if (hs[i]) req_in_sync[i] = 1'b0;
      if (!req_in_sync[i]) begin
        if (fill_mode == 1) begin
          req_in[i*W +: W] = 32'hA000_0000 + 32'(i*256 + seq[i]);
          seq[i]++;
          req_in_sync[i] = 1'b1;
        end else if (fill_mode == 2 && $urandom_range(1) == 1) begin
          req_in[i*W +: W] = $urandom;
          req_in_sync[i] = 1'b1;
        end
      end
    end
    b_out_sync = ($urandom_range(99) < bready_pct);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check_outputs();
    drive_next();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    fill_mode = 0;
    req_in_sync = '0;
    for (int i = 0; i < N; i++) seq[i] = 0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < N; i++) seq[i] = 0;

    // Reset held three cycles, then idle with no requests.
    bready_pct = 100;
    b_out_sync = 1'b1;
    tick(); tick(); tick();
    rst = 1'b1;
    tick(); tick();
    chk("t1_req_in_notify", 64'(req_in_notify), 64'h0);
    chk("t1_b_out_notify", 64'(b_out_notify), 64'h0);
    chk("t1_m_out", 64'(m_out), 64'h0);
    chk("t1_m_out_notify", 64'(m_out_notify), 64'h0);

    // Single requester 2.
    req_in[2*W +: W] = 32'h0000_0539;
    req_in_sync[2] = 1'b1;
    tick();
    chk("t2_grant", 64'(req_in_notify), 64'b0100);
    tick();
    chk("t2_b_out", 64'(b_out), 64'd1337);
    chk("t2_b_out_notify", 64'(b_out_notify), 64'h1);
    chk("t2_notify_off", 64'(req_in_notify), 64'h0);
    tick();
    chk("t2_m_out", 64'(m_out), 64'h201);
    chk("t2_m_out_notify", 64'(m_out_notify), 64'h1);
    tick();
    chk("t2_m_strobe_once", 64'(m_out_notify), 64'h0);
    chk("t2_m_out_hold", 64'(m_out), 64'h201);

    // All four requesters offering continuously.
    do_reset();
    obs_m.delete(); obs_b.delete();
    fill_mode = 1;
    bready_pct = 100;
    for (int c = 0; c < 100 && obs_m.size() < 5; c++) tick();
    chk("t3_transfers_done", 64'(obs_m.size() >= 5), 64'h1);
    if (obs_m.size() >= 5) begin
      chk("t3_m0", 64'(obs_m[0]), 64'h001);
      chk("t3_m1", 64'(obs_m[1]), 64'h102);
      chk("t3_m2", 64'(obs_m[2]), 64'h203);
      chk("t3_m3", 64'(obs_m[3]), 64'h304);
      chk("t3_m4", 64'(obs_m[4]), 64'h005);
      chk("t3_b0", 64'(obs_b[0]), 64'hA000_0000);
      chk("t3_b1", 64'(obs_b[1]), 64'hA000_0100);
      chk("t3_b2", 64'(obs_b[2]), 64'hA000_0200);
      chk("t3_b3", 64'(obs_b[3]), 64'hA000_0300);
      chk("t3_b4", 64'(obs_b[4]), 64'hA000_0001);
    end

    // Consumer backpressure for 10 cycles while another producer waits.
    do_reset();
    bready_pct = 0;
    b_out_sync = 1'b0;
    req_in[1*W +: W] = 32'hBEEF_0001;
    req_in_sync[1] = 1'b1;
    tick(); tick();
    req_in[3*W +: W] = 32'hBEEF_0003;
    req_in_sync[3] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("t4_b_out", 64'(b_out), 64'hBEEF_0001);
      chk("t4_b_out_notify", 64'(b_out_notify), 64'h1);
      chk("t4_no_grant", 64'(req_in_notify), 64'h0);
    end
    bready_pct = 100;
    b_out_sync = 1'b1;
    tick();
    chk("t4_m_out", 64'(m_out), 64'h101);
    chk("t4_m_out_notify", 64'(m_out_notify), 64'h1);
    tick();
    chk("t4_next_grant", 64'(req_in_notify), 64'b1000);

    // Counter wrap over 257 transfers.
    do_reset();
    obs_m.delete(); obs_b.delete();
    fill_mode = 1;
    bready_pct = 100;
    for (int c = 0; c < 1000 && obs_m.size() < 257; c++) tick();
    chk("t5_transfers_done", 64'(obs_m.size() >= 257), 64'h1);
    if (obs_m.size() >= 257) begin
      chk("t5_cnt255", 64'(obs_m[254]), 64'h2FF);
      chk("t5_cnt0", 64'(obs_m[255]), 64'h300);
      chk("t5_ptr_wrap", 64'(obs_m[256]), 64'h001);
    end

    // Reset during SEND.
    do_reset();
    bready_pct = 100;
    b_out_sync = 1'b1;
    req_in[1*W +: W] = 32'h0000_0011;
    req_in_sync[1] = 1'b1;
    tick(); tick(); tick(); tick();
    bready_pct = 0;
    b_out_sync = 1'b0;
    req_in[2*W +: W] = 32'h0000_0022;
    req_in_sync[2] = 1'b1;
    tick(); tick();
    chk("t6_in_send", 64'(b_out_notify), 64'h1);
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk("t6_async_b_out_notify", 64'(b_out_notify), 64'h0);
    chk("t6_async_m_out_notify", 64'(m_out_notify), 64'h0);
    chk("t6_async_b_out", 64'(b_out), 64'h0);
    chk("t6_async_m_out", 64'(m_out), 64'h0);
    req_in[1*W +: W] = 32'h0000_0031;
    req_in[3*W +: W] = 32'h0000_0033;
    req_in_sync[1] = 1'b1;
    req_in_sync[3] = 1'b1;
    tick(); tick();
    rst = 1'b1;
    bready_pct = 100;
    b_out_sync = 1'b1;
    tick();
    chk("t6_grant_from_zero", 64'(req_in_notify), 64'b0010);
    tick(); tick();
    chk("t6_first_count", 64'(m_out), 64'h101);

    // Randomised traffic with random consumer stalls.
    do_reset();
    fill_mode = 2;
    bready_pct = 60;
    for (int c = 0; c < 3000; c++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
